demux_1_4_stream: RTL and testbench
===================================

DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of the input and of each output channel.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL mark in_data/in_sel as valid.
REQ-005 in_ready  output  1  SHALL mean the block accepts the input this cycle.
REQ-006 in_data  input  WIDTH  SHALL be the payload to route.
REQ-007 in_sel  input  2  SHALL be the destination channel index (0..3).
REQ-008 out_valid  output  4  SHALL hold one valid bit per channel; bit k belongs to channel k.
REQ-009 out_ready  input  4  SHALL hold one ready bit per channel from the downstream consumer.
REQ-010 out_data0, out_data1, out_data2, out_data3  output  WIDTH each  SHALL be the registered payload of channels 0..3.
REQ-011 out_count0..out_count3  output  8 each  SHALL be the number of words delivered on channels 0..3.

Function
REQ-012 The block SHALL be the inverse of the 4:1 gate mux: one input stream routed to exactly one of four registered output channels.
REQ-013 Each channel SHALL have a one-entry holding register (data plus valid bit).
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-015 An output transfer on channel k SHALL occur when out_valid[k] and out_ready[k] are both 1 on a rising edge.
REQ-016 in_ready SHALL equal (~out_valid[in_sel]) | out_ready[in_sel]: combinational, selected-channel only, independent of in_valid.
REQ-017 Latency: a word accepted at edge N SHALL appear on out_data<in_sel> with out_valid[in_sel]=1 after edge N.
REQ-018 Per channel: input transfer and no output transfer SHALL set valid and load data.
REQ-019 Per channel: output transfer and no input transfer SHALL clear valid; data SHALL keep its last value.
REQ-020 Per channel: simultaneous output and input transfer SHALL keep valid=1 and load the new data; throughput SHALL be 1 word/cycle to a channel that is always ready.
REQ-021 While out_valid[k]=1 and out_ready[k]=0, out_data<k> SHALL stay stable and out_valid[k] SHALL stay 1.
REQ-022 A stall on channel k SHALL only block inputs with in_sel=k; inputs to other channels SHALL proceed in the same cycle.
REQ-023 Only channel in_sel SHALL change on an input transfer; other channels' data and valid SHALL be unaffected except by their own output transfers.
REQ-024 out_count<k> SHALL increment by 1 on each output transfer of channel k and SHALL wrap 255 -> 0.
REQ-025 in_sel and in_data SHALL be ignored when in_valid=0; no channel state SHALL change from them.
REQ-026 Per-channel update logic SHALL use the same select decode as the 4:1 mux: four one-hot terms from in_sel[1:0].

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force out_valid=4'b0000, all out_data=0, and all out_count=0.
REQ-028 During reset, in_ready SHALL follow REQ-016 from the cleared state, reading 1, but no transfer SHALL be recorded.
REQ-029 Reset asserted mid-operation SHALL discard held words without delivering them.
REQ-030 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Basic routing: after reset, send 'ha/sel0, 'hb/sel1, 'hc/sel2, 'hd/sel3 with all out_ready=1 -> each word appears on its own channel one cycle later; each out_count = 1.
REQ-032 Backpressure: out_ready[2]=0, send 'h5/sel2 then 'h6/sel2 -> in_ready=0 on the second word; out_data2 stays 'h5; raise out_ready[2] -> 'h5 is delivered, then 'h6.
REQ-033 Independence: channel 1 stalled holding 'h3; send 'h7/sel0 -> accepted the same cycle; out_data1 stays 'h3.
REQ-034 Full rate: channel 3 ready continuously, 10 back-to-back words 0..9 -> one word delivered per cycle, in order; out_count3 = 10.
REQ-035 Wrap and reset: 256 transfers on channel 0 -> out_count0 = 0; next, hold a word on channel 1 and pulse rst_n low between edges -> out_valid and all counts go to 0 immediately.

Source files
------------

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes one valid/ready stream (in_*) by in_sel to one of four registered channels (out_valid/out_ready/out_data0-3), counting deliveries per channel in out_count0-3
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       out_count0,
  output logic [7:0]       out_count1,
  output logic [7:0]       out_count2,
  output logic [7:0]       out_count3
);
  logic [3:0]       sel_oh, ld, dl, vld_q;
  logic [WIDTH-1:0] data_q [4];
  logic [7:0]       cnt_q [4];
  assign sel_oh    = 4'b0001 << in_sel;
  assign in_ready  = ~vld_q[in_sel] | out_ready[in_sel];
  assign ld        = {4{in_valid & in_ready}} & sel_oh;
  assign dl        = vld_q & out_ready;
  assign out_valid = vld_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_count0 = cnt_q[0];
  assign out_count1 = cnt_q[1];
  assign out_count2 = cnt_q[2];
  assign out_count3 = cnt_q[3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      vld_q <= ld | (vld_q & ~dl);
      for (int k = 0; k < 4; k++) begin
        if (ld[k]) data_q[k] <= in_data;
        if (dl[k]) cnt_q[k] <= cnt_q[k] + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: directed table-driven bench for demux_1_4_stream
module tb_demux_1_4_stream;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic [3:0] out_valid, out_ready = '0;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0] out_count0, out_count1, out_count2, out_count3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  demux_1_4_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_count0(out_count0), .out_count1(out_count1), .out_count2(out_count2), .out_count3(out_count3)
  );

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       rdy;
    int         chk;
    logic [3:0] ov;
    logic [3:0] dat;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl [16];

  function automatic logic [W-1:0] od(int k);
    return k == 0 ? out_data0 : k == 1 ? out_data1 : k == 2 ? out_data2 : out_data3;
  endfunction

  function automatic logic [7:0] oc(int k);
    return k == 0 ? out_count0 : k == 1 ? out_count1 : k == 2 ? out_count2 : out_count3;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic [1:0] sel, logic [3:0] d, logic [3:0] ordy);
    @(negedge clk);
    in_valid  = iv;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic check_cleared(string tag);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " in_ready"}, in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s data%0d", tag, k), od(k), 0);
      check($sformatf("%s count%0d", tag, k), oc(k), 0);
    end
  endtask

  initial begin
    // basic routing, then idle reads to confirm counts and that idle in_data is ignored
    tbl[0]  = '{1, 0, 4'ha, 4'hf, 1, 0, 4'b0001, 4'ha, 0};
    tbl[1]  = '{1, 1, 4'hb, 4'hf, 1, 1, 4'b0010, 4'hb, 0};
    tbl[2]  = '{1, 2, 4'hc, 4'hf, 1, 2, 4'b0100, 4'hc, 0};
    tbl[3]  = '{1, 3, 4'hd, 4'hf, 1, 3, 4'b1000, 4'hd, 0};
    tbl[4]  = '{0, 0, 4'h0, 4'hf, 1, 3, 4'b0000, 4'hd, 1};
    tbl[5]  = '{0, 0, 4'h5, 4'hf, 1, 0, 4'b0000, 4'ha, 1};
    tbl[6]  = '{0, 1, 4'h6, 4'hf, 1, 1, 4'b0000, 4'hb, 1};
    tbl[7]  = '{0, 2, 4'h7, 4'hf, 1, 2, 4'b0000, 4'hc, 1};
    // backpressure on channel 2
    tbl[8]  = '{1, 2, 4'h5, 4'hb, 1, 2, 4'b0100, 4'h5, 1};
    tbl[9]  = '{1, 2, 4'h6, 4'hb, 0, 2, 4'b0100, 4'h5, 1};
    tbl[10] = '{1, 2, 4'h6, 4'hf, 1, 2, 4'b0100, 4'h6, 2};
    tbl[11] = '{0, 2, 4'h0, 4'hf, 1, 2, 4'b0000, 4'h6, 3};
    // channel 1 stalled must not block channel 0
    tbl[12] = '{1, 1, 4'h3, 4'hd, 1, 1, 4'b0010, 4'h3, 1};
    tbl[13] = '{1, 0, 4'h7, 4'hd, 1, 1, 4'b0011, 4'h3, 1};
    tbl[14] = '{0, 1, 4'h0, 4'hd, 0, 0, 4'b0010, 4'h7, 2};
    tbl[15] = '{0, 1, 4'h0, 4'hf, 1, 1, 4'b0000, 4'h3, 2};

    #1 check_cleared("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].ordy);
      #1 check($sformatf("v%0d in_ready", i), in_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("v%0d data%0d", i, tbl[i].chk), od(tbl[i].chk), tbl[i].dat);
      check($sformatf("v%0d count%0d", i, tbl[i].chk), oc(tbl[i].chk), tbl[i].cnt);
    end

    // full rate on channel 3 (count3 already 1 from routing test)
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, 4'(i), 4'hf);
      #1 check($sformatf("burst%0d in_ready", i), in_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("burst%0d out_valid", i), out_valid, 4'b1000);
      check($sformatf("burst%0d data3", i), out_data3, i);
      check($sformatf("burst%0d count3", i), out_count3, 1 + i);
    end
    drive(0, 3, 0, 4'hf);
    @(posedge clk);
    #1 check("burst count3 final", out_count3, 11);

    // channel 0 count is 2; 254 more deliveries wrap it through 255 to 0
    for (int i = 0; i < 254; i++) begin
      drive(1, 0, 4'(i), 4'hf);
      @(posedge clk);
    end
    #1 check("wrap count0 at 255", out_count0, 255);
    drive(0, 0, 0, 4'hf);
    @(posedge clk);
    #1 check("wrap count0 to 0", out_count0, 0);

    // hold a word on channel 1, then asynchronous reset between edges
    drive(1, 1, 4'h9, 4'hd);
    @(posedge clk);
    #1 check("hold out_valid", out_valid, 4'b0010);
    check("hold data1", out_data1, 4'h9);
    #2 rst_n = 0;
    #1 check_cleared("async reset");
    @(posedge clk);
    #1 check("reset no transfer", out_valid, 0);
    check("reset count1", out_count1, 0);

    // first edge after release must accept
    drive(1, 2, 4'he, 4'hf);
    rst_n = 1;
    #1 check("post reset in_ready", in_ready, 1);
    @(posedge clk);
    #1 check("post reset out_valid", out_valid, 4'b0100);
    check("post reset data2", out_data2, 4'he);
    check("post reset count2", out_count2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
